// File: rtl/imem_loadable_if.sv
// Fetch/loader bus of the loadable instruction memory: the debug-unit byte
// loader plus the PC-side read port, seen from the driver (master) and the memory (slave).
interface imem_loadable_if #(
    parameter int NB_INST = 32,
    parameter int NB_ADDR = 7,
    parameter int NB_BYTE = 8
);
    logic               i_load_start;
    logic               i_load_valid;
    logic [NB_BYTE-1:0] i_load_byte;
    logic               o_load_ready;
    logic               o_load_done;
    logic [NB_ADDR:0]   o_load_count;
    logic [NB_ADDR+1:0] i_pc;
    logic               i_en_read;
    logic               i_stall;
    logic               i_flush;
    logic [NB_INST-1:0] o_instr;
    logic               o_instr_valid;
    logic               o_addr_err;
    logic               o_busy;

    modport master (
        output i_load_start, i_load_valid, i_load_byte,
        output i_pc, i_en_read, i_stall, i_flush,
        input  o_load_ready, o_load_done, o_load_count,
        input  o_instr, o_instr_valid, o_addr_err, o_busy
    );

    modport slave (
        input  i_load_start, i_load_valid, i_load_byte,
        input  i_pc, i_en_read, i_stall, i_flush,
        output o_load_ready, o_load_done, o_load_count,
        output o_instr, o_instr_valid, o_addr_err, o_busy
    );
endinterface

// File: rtl/imem_loadable.sv
// Instruction memory for Fetch: HALT-fills itself after reset, accepts a
// byte-stream program load, and serves 1-cycle synchronous byte-addressed reads.
module imem_loadable #(
    parameter int                 NB_INST     = 32,
    parameter int                 N_WORDS     = 128,
    parameter int                 NB_ADDR     = $clog2(N_WORDS),
    parameter int                 NB_BYTE     = 8,
    parameter logic [NB_INST-1:0] HALT_OPCODE = 32'hF800_0000
) (
    input  logic          i_clk,
    input  logic          i_reset,
    imem_loadable_if.slave bus
);
    // Assumes at least two bytes per word, so the shift register slice is non-empty.
    localparam int NB_PER_W = NB_INST / NB_BYTE;
    localparam int NB_BCNT  = (NB_PER_W > 1) ? $clog2(NB_PER_W) : 1;
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_PER_W - 1);
    localparam logic [NB_ADDR-1:0] LAST_WORD = NB_ADDR'(N_WORDS - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOAD} state_t;

    logic [NB_INST-1:0] r_mem [N_WORDS];
    state_t             r_state;
    logic [NB_ADDR-1:0] r_clr_ptr;
    logic [NB_ADDR-1:0] r_wr_ptr;
    logic [NB_BCNT-1:0] r_byte_cnt;
    logic [NB_INST-1:0] r_shreg;
    logic               r_load_ready;
    logic               r_load_done;
    logic [NB_ADDR:0]   r_load_count;
    logic               r_busy;
    logic [NB_INST-1:0] r_instr;
    logic               r_instr_valid;
    logic               r_addr_err;

    logic               w_accept;
    logic               w_last_byte;
    logic [NB_INST-1:0] w_word;
    logic               w_we;
    logic [NB_ADDR-1:0] w_waddr;
    logic [NB_INST-1:0] w_wdata;

    assign w_accept    = r_load_ready && bus.i_load_valid;
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);
    assign w_word      = {r_shreg[NB_INST-NB_BYTE-1:0], bus.i_load_byte};

    // Single write port shared by the clearer and the loader; reset suppresses both.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_ptr;
        w_wdata = HALT_OPCODE;
        if (!i_reset) begin
            if (r_state == ST_CLEAR) begin
                w_we = 1'b1;
            end else if (r_state == ST_LOAD && w_accept && w_last_byte) begin
                w_we    = 1'b1;
                w_waddr = r_wr_ptr;
                w_wdata = w_word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_CLEAR;
            r_clr_ptr    <= '0;
            r_wr_ptr     <= '0;
            r_byte_cnt   <= '0;
            r_shreg      <= '0;
            r_load_ready <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_count <= '0;
            r_busy       <= 1'b1;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LAST_WORD) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.i_load_start) begin
                        r_state      <= ST_LOAD;
                        r_busy       <= 1'b1;
                        r_load_ready <= 1'b1;
                        r_wr_ptr     <= '0;
                        r_byte_cnt   <= '0;
                        r_load_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_shreg <= w_word;
                        if (w_last_byte) begin
                            r_byte_cnt   <= '0;
                            r_wr_ptr     <= r_wr_ptr + 1'b1;
                            r_load_count <= r_load_count + 1'b1;
                            // Terminate on HALT or once the top word has been written.
                            if (w_word == HALT_OPCODE || r_wr_ptr == LAST_WORD) begin
                                r_state      <= ST_IDLE;
                                r_busy       <= 1'b0;
                                r_load_ready <= 1'b0;
                                r_load_done  <= 1'b1;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_CLEAR;
                    r_clr_ptr    <= '0;
                    r_busy       <= 1'b1;
                    r_load_ready <= 1'b0;
                end
            endcase
        end
    end

    // Read port priority: flush, busy, stall, read request, idle.
    always_ff @(posedge i_clk) begin
        if (i_reset || bus.i_flush) begin
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_addr_err    <= 1'b0;
        end else if (r_busy) begin
            r_instr_valid <= 1'b0;
        end else if (!bus.i_stall) begin
            if (bus.i_en_read) begin
                if (bus.i_pc[1:0] != 2'b00) begin
                    r_instr       <= '0;
                    r_instr_valid <= 1'b0;
                    r_addr_err    <= 1'b1;
                end else begin
                    r_instr       <= r_mem[bus.i_pc[NB_ADDR+1:2]];
                    r_instr_valid <= 1'b1;
                    r_addr_err    <= 1'b0;
                end
            end else begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign bus.o_load_ready  = r_load_ready;
    assign bus.o_load_done   = r_load_done;
    assign bus.o_load_count  = r_load_count;
    assign bus.o_busy        = r_busy;
    assign bus.o_instr       = r_instr;
    assign bus.o_instr_valid = r_instr_valid;
    assign bus.o_addr_err    = r_addr_err;
endmodule
